// File: rtl/microseq_pkg.sv
// Shared types for the microprogram sequencer: sequencing ops, FSM states,
// microword field offsets and the instruction opcodes that select func3 dispatch.
package microseq_pkg;

   typedef enum logic [1:0] {
      END    = 2'b00,
      NEXT   = 2'b01,
      WAIT   = 2'b10,
      BRANCH = 2'b11
   } seq_op_e;

   typedef enum logic {
      DISPATCH = 1'b0,
      RUN      = 1'b1
   } state_e;

   // Opcodes whose func3 (and for two of them bit 30) refine the dispatch address
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // The ctrl field sits above the 2-bit seq op and the AW-bit next field
   function automatic int ctrl_lsb(input int aw);
      return aw + 2;
   endfunction

endpackage

// File: rtl/microseq_ctrl_ucode_store.sv
// Writable control store: asynchronous read, synchronous write.
// Reset never touches the contents; a same-cycle read of a written entry sees old data.
module ucode_store #(
   parameter int AW = 9,
   parameter int UW = 32
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [UW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [UW-1:0] o_rdata
);

   logic [UW-1:0] r_mem [2**AW];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer: instruction dispatch decode, DISPATCH/RUN FSM and the
// WAIT watchdog, driving datapath control straight from the writable control store.
module microseq_ctrl
   import microseq_pkg::*;
#(
   parameter int  CTRL_W   = 21,
   parameter int  AW       = 9,
   parameter int  MAX_WAIT = 16,
   localparam int UW       = CTRL_W + 2 + AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruction,
   input  logic              instr_valid,
   input  logic              mem_ready,
   input  logic              ex_cond,
   input  logic              ex_abort,
   input  logic              ucode_we,
   input  logic [AW-1:0]     ucode_waddr,
   input  logic [UW-1:0]     ucode_wdata,
   output logic [CTRL_W-1:0] ctrl_signals,
   output logic              busy,
   output logic              instr_done,
   output logic [AW-1:0]     upc,
   output logic              wait_timeout
);

   localparam int CL  = ctrl_lsb(AW);
   localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   state_e          r_state;
   logic [AW-1:0]   r_upc;
   logic [WCW-1:0]  r_waitCnt;
   logic            r_waitTimeout;

   logic [6:0]      w_opcode;
   logic            w_hasFunc3;
   logic            w_altBit;
   logic [AW-1:0]   w_dispAddr;
   logic [AW-1:0]   w_curAddr;
   logic [UW-1:0]   w_word;
   seq_op_e         w_op;
   logic [AW-1:0]   w_next;
   logic            w_active;
   logic            w_unusedBits;

   assign w_opcode     = instruction[6:0];
   assign w_unusedBits = ^{instruction[31], instruction[29:15], instruction[11:7]};

   // Dispatch address: opcode[6:2] selects a 16-word block, func3 and bit 30 pick within it
   always_comb begin
      w_hasFunc3 = 1'b0;
      w_altBit   = 1'b0;
      w_dispAddr = '0;
      case (w_opcode)
         OPC_OP: begin
            w_hasFunc3 = 1'b1;
            w_altBit   = instruction[30];
         end
         OPC_OP_IMM: begin
            w_hasFunc3 = 1'b1;
            w_altBit   = (instruction[14:12] == 3'b101) && instruction[30];
         end
         OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH: w_hasFunc3 = 1'b1;
         default: w_hasFunc3 = 1'b0;
      endcase
      w_dispAddr[8:4] = instruction[6:2];
      w_dispAddr[3:1] = w_hasFunc3 ? instruction[14:12] : 3'b000;
      w_dispAddr[0]   = w_altBit;
   end

   assign w_active  = (r_state == RUN) || instr_valid;
   assign w_curAddr = (r_state == RUN) ? r_upc : w_dispAddr;

   ucode_store #(
      .AW(AW),
      .UW(UW)
   ) u_store (
      .clk     (clk),
      .i_we    (ucode_we),
      .i_waddr (ucode_waddr),
      .i_wdata (ucode_wdata),
      .i_raddr (w_curAddr),
      .o_rdata (w_word)
   );

   assign w_op   = seq_op_e'(w_word[AW+1:AW]);
   assign w_next = w_word[AW-1:0];

   // Zero-latency outputs: the current microword drives the datapath in the same cycle
   assign ctrl_signals = (rst || !w_active) ? '0 : w_word[UW-1:CL];
   assign instr_done   = !rst && w_active && !ex_abort &&
                         ((w_op == END) || ((w_op == BRANCH) && !ex_cond));
   assign busy         = (r_state == RUN);
   assign upc          = w_curAddr;
   assign wait_timeout = r_waitTimeout;

   // Sequencing FSM; abort outranks everything, and a late mem_ready beats the watchdog
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= DISPATCH;
         r_upc         <= '0;
         r_waitCnt     <= '0;
         r_waitTimeout <= 1'b0;
      end else if (ex_abort) begin
         r_state   <= DISPATCH;
         r_waitCnt <= '0;
      end else if (w_active) begin
         unique case (w_op)
            END: r_state <= DISPATCH;
            NEXT: begin
               r_upc   <= w_next;
               r_state <= RUN;
            end
            WAIT: begin
               if (mem_ready) begin
                  r_upc     <= w_next;
                  r_state   <= RUN;
                  r_waitCnt <= '0;
               end else if (r_waitCnt == WCW'(MAX_WAIT - 1)) begin
                  r_waitTimeout <= 1'b1;
                  r_state       <= DISPATCH;
                  r_waitCnt     <= '0;
               end else begin
                  r_upc     <= w_curAddr;
                  r_state   <= RUN;
                  r_waitCnt <= r_waitCnt + 1'b1;
               end
            end
            BRANCH: begin
               if (ex_cond) begin
                  r_upc   <= w_next;
                  r_state <= RUN;
               end else begin
                  r_state <= DISPATCH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_microseq_ctrl.sv
// Self-checking bench for microseq_ctrl: directed scenarios plus randomized
// microprograms checked against a trace-level reference model.
module tb_microseq_ctrl;

   localparam logic [31:0] INS_ADD  = 32'h00208033;
   localparam logic [31:0] INS_SUB  = 32'h40208033;
   localparam logic [31:0] INS_LW   = 32'h0000A003;
   localparam logic [31:0] INS_BEQ  = 32'h00000063;
   localparam logic [31:0] INS_LUI  = 32'h000000B7;

   localparam int OP_END = 0, OP_NEXT = 1, OP_WAIT = 2, OP_BRANCH = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic        instr_valid, mem_ready, ex_cond, ex_abort;
   logic        ucode_we;
   logic [8:0]  ucode_waddr;
   logic [31:0] ucode_wdata;
   logic [20:0] ctrl_signals;
   logic        busy, instr_done, wait_timeout;
   logic [8:0]  upc;

   logic        we10;
   logic [9:0]  waddr10;
   logic [32:0] wdata10;
   logic [20:0] ctrl10;
   logic        busy10, done10, timeout10;
   logic [9:0]  upc10;

   int passCount = 0;
   int checkCount = 0;

   logic [20:0] mCtrl [512];
   logic [6:0]  opcTab [7] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37};

   typedef struct {
      int addr;
      int ctrl;
      bit mr;
      bit cond;
      bit done;
      bit busy;
   } step_t;

   step_t trace[$];

   microseq_ctrl #(.CTRL_W(21), .AW(9), .MAX_WAIT(16)) u_dut (
      .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
      .mem_ready(mem_ready), .ex_cond(ex_cond), .ex_abort(ex_abort),
      .ucode_we(ucode_we), .ucode_waddr(ucode_waddr), .ucode_wdata(ucode_wdata),
      .ctrl_signals(ctrl_signals), .busy(busy), .instr_done(instr_done),
      .upc(upc), .wait_timeout(wait_timeout)
   );

   microseq_ctrl #(.CTRL_W(21), .AW(10), .MAX_WAIT(16)) u_dut10 (
      .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
      .mem_ready(mem_ready), .ex_cond(ex_cond), .ex_abort(ex_abort),
      .ucode_we(we10), .ucode_waddr(waddr10), .ucode_wdata(wdata10),
      .ctrl_signals(ctrl10), .busy(busy10), .instr_done(done10),
      .upc(upc10), .wait_timeout(timeout10)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeWord(input int addr, input int ctrl, input int op, input int nxt);
      ucode_we    = 1'b1;
      ucode_waddr = addr[8:0];
      ucode_wdata = {ctrl[20:0], op[1:0], nxt[8:0]};
      mCtrl[addr] = ctrl[20:0];
      tick();
      ucode_we = 1'b0;
   endtask

   // Reference dispatch address built from the instruction fields with plain arithmetic
   function automatic int dispAddr(input logic [31:0] ins);
      int opc;
      int f3;
      bit hasF3;
      bit hasAlt;
      opc    = int'(ins[6:0]);
      f3     = int'(ins[14:12]);
      hasF3  = (opc == 'h33) || (opc == 'h13) || (opc == 'h03) ||
               (opc == 'h67) || (opc == 'h23) || (opc == 'h63);
      hasAlt = (opc == 'h33) || ((opc == 'h13) && (f3 == 5));
      return (opc / 4) * 16 + (hasF3 ? f3 * 2 : 0) + ((hasAlt && ins[30]) ? 1 : 0);
   endfunction

   task automatic test_reset();
      instruction = INS_ADD;
      instr_valid = 1'b1;
      @(negedge clk);
      checkCount++; if (ctrl_signals !== 21'h0) $display("[TB] FAIL reset_ctrl: got %h want 0", ctrl_signals); else passCount++;
      checkCount++; if (instr_done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", instr_done); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
      checkCount++; if (wait_timeout !== 1'b0) $display("[TB] FAIL reset_timeout: got %b want 0", wait_timeout); else passCount++;
      tick();
      rst = 1'b0;
      instr_valid = 1'b0;
      @(negedge clk);
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b want 0", busy); else passCount++;
      checkCount++; if (ctrl_signals !== 21'h0) $display("[TB] FAIL idle_ctrl: got %h want 0", ctrl_signals); else passCount++;
      tick();
   endtask

   task automatic test_end_op();
      writeWord('h0C0, 'h1, OP_END, 0);
      instruction = INS_ADD;
      instr_valid = 1'b1;
      @(negedge clk);
      checkCount++; if (ctrl_signals !== 21'h1) $display("[TB] FAIL add_ctrl: got %h want 1", ctrl_signals); else passCount++;
      checkCount++; if (instr_done !== 1'b1) $display("[TB] FAIL add_done: got %b want 1", instr_done); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL add_busy: got %b want 0", busy); else passCount++;
      checkCount++; if (upc !== 9'h0C0) $display("[TB] FAIL add_upc: got %h want 0c0", upc); else passCount++;
      tick();
      instr_valid = 1'b0;
      @(negedge clk);
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL add_after_busy: got %b want 0", busy); else passCount++;
      checkCount++; if (instr_done !== 1'b0) $display("[TB] FAIL add_after_done: got %b want 0", instr_done); else passCount++;
      checkCount++; if (ctrl_signals !== 21'h0) $display("[TB] FAIL add_after_ctrl: got %h want 0", ctrl_signals); else passCount++;
      tick();
   endtask

   task automatic test_wait();
      bit          mrTab   [5] = '{0, 0, 0, 1, 0};
      logic [8:0]  upcTab  [5] = '{9'h004, 9'h004, 9'h004, 9'h004, 9'h005};
      logic [20:0] ctrlTab [5] = '{21'h2, 21'h2, 21'h2, 21'h2, 21'h3};
      bit          busyTab [5] = '{0, 1, 1, 1, 1};
      bit          doneTab [5] = '{0, 0, 0, 0, 1};
      writeWord('h004, 'h2, OP_WAIT, 'h005);
      writeWord('h005, 'h3, OP_END, 0);
      instruction = INS_LW;
      instr_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         mem_ready = mrTab[c];
         @(negedge clk);
         checkCount++;
         if ({upc, ctrl_signals, busy, instr_done} !== {upcTab[c], ctrlTab[c], busyTab[c], doneTab[c]})
            $display("[TB] FAIL wait_cycle%0d: got upc=%h ctrl=%h busy=%b done=%b want upc=%h ctrl=%h busy=%b done=%b",
                     c, upc, ctrl_signals, busy, instr_done, upcTab[c], ctrlTab[c], busyTab[c], doneTab[c]);
         else passCount++;
         tick();
      end
      instr_valid = 1'b0;
      mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int badCycle = -1;
      instruction = INS_LW;
      instr_valid = 1'b1;
      mem_ready = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (badCycle < 0 && (instr_done !== 1'b0 || upc !== 9'h004 || wait_timeout !== 1'b0 || busy !== (c > 0)))
            badCycle = c;
         tick();
      end
      checkCount++; if (badCycle >= 0) $display("[TB] FAIL timeout_window: bad at cycle %0d got upc=%h busy=%b done=%b to=%b want stalled at 004 with no done/timeout", badCycle, upc, busy, instr_done, wait_timeout); else passCount++;
      @(negedge clk);
      checkCount++; if (wait_timeout !== 1'b1) $display("[TB] FAIL timeout_flag: got %b want 1", wait_timeout); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL timeout_busy: got %b want 0", busy); else passCount++;
      instr_valid = 1'b0;
      tick();
      @(negedge clk);
      checkCount++; if (wait_timeout !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b want 1", wait_timeout); else passCount++;
      tick();
   endtask

   task automatic test_branch();
      writeWord('h180, 'h4, OP_BRANCH, 'h1F0);
      instruction = INS_BEQ;
      instr_valid = 1'b1;
      ex_cond = 1'b0;
      @(negedge clk);
      checkCount++; if (instr_done !== 1'b1) $display("[TB] FAIL br_nt_done: got %b want 1", instr_done); else passCount++;
      checkCount++; if (ctrl_signals !== 21'h4) $display("[TB] FAIL br_nt_ctrl: got %h want 4", ctrl_signals); else passCount++;
      checkCount++; if (upc !== 9'h180) $display("[TB] FAIL br_nt_upc: got %h want 180", upc); else passCount++;
      tick();
      ex_cond = 1'b1;
      @(negedge clk);
      checkCount++; if (instr_done !== 1'b0) $display("[TB] FAIL br_t_done: got %b want 0", instr_done); else passCount++;
      tick();
      ex_cond = 1'b0;
      @(negedge clk);
      checkCount++; if (upc !== 9'h1F0) $display("[TB] FAIL br_t_upc: got %h want 1f0", upc); else passCount++;
      checkCount++; if (busy !== 1'b1) $display("[TB] FAIL br_t_busy: got %b want 1", busy); else passCount++;
      checkCount++; if ({ctrl_signals, instr_done} !== {21'h0, 1'b1}) $display("[TB] FAIL br_t_nop: got ctrl=%h done=%b want ctrl=0 done=1", ctrl_signals, instr_done); else passCount++;
      instr_valid = 1'b0;
      tick();
   endtask

   task automatic test_abort_reset();
      int badCycle = -1;
      instruction = INS_LW;
      instr_valid = 1'b1;
      mem_ready = 1'b0;
      repeat (3) begin @(negedge clk); tick(); end
      rst = 1'b1;
      @(negedge clk);
      checkCount++; if ({ctrl_signals, instr_done} !== 22'h0) $display("[TB] FAIL rst_run_outs: got ctrl=%h done=%b want 0/0", ctrl_signals, instr_done); else passCount++;
      tick();
      rst = 1'b0;
      instr_valid = 1'b0;
      @(negedge clk);
      checkCount++; if ({busy, wait_timeout} !== 2'b00) $display("[TB] FAIL rst_run_state: got busy=%b to=%b want 0/0", busy, wait_timeout); else passCount++;
      tick();
      instruction = INS_ADD;
      instr_valid = 1'b1;
      @(negedge clk);
      checkCount++; if ({ctrl_signals, instr_done} !== {21'h1, 1'b1}) $display("[TB] FAIL rst_store_kept: got ctrl=%h done=%b want 1/1", ctrl_signals, instr_done); else passCount++;
      tick();
      instruction = INS_LW;
      repeat (3) begin @(negedge clk); tick(); end
      ex_abort = 1'b1;
      @(negedge clk);
      checkCount++; if ({ctrl_signals, instr_done} !== {21'h2, 1'b0}) $display("[TB] FAIL abort_outs: got ctrl=%h done=%b want 2/0", ctrl_signals, instr_done); else passCount++;
      tick();
      ex_abort = 1'b0;
      instr_valid = 1'b0;
      @(negedge clk);
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else passCount++;
      tick();
      instr_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (badCycle < 0 && (busy !== (c > 0) || wait_timeout !== 1'b0)) badCycle = c;
         tick();
      end
      checkCount++; if (badCycle >= 0) $display("[TB] FAIL abort_cnt_clear: early end at cycle %0d got busy=%b to=%b want full 16-cycle wait", badCycle, busy, wait_timeout); else passCount++;
      @(negedge clk);
      checkCount++; if ({busy, wait_timeout} !== 2'b01) $display("[TB] FAIL abort_cnt_expire: got busy=%b to=%b want 0/1", busy, wait_timeout); else passCount++;
      instr_valid = 1'b0;
      tick();
      writeWord('h0D0, 'h5, OP_NEXT, 'h0D0);
      instruction = INS_LUI;
      instr_valid = 1'b1;
      repeat (3) begin @(negedge clk); tick(); end
      @(negedge clk);
      checkCount++; if ({upc, ctrl_signals, busy, instr_done} !== {9'h0D0, 21'h5, 1'b1, 1'b0}) $display("[TB] FAIL loop_hold: got upc=%h ctrl=%h busy=%b done=%b want 0d0/5/1/0", upc, ctrl_signals, busy, instr_done); else passCount++;
      ex_abort = 1'b1;
      tick();
      ex_abort = 1'b0;
      instr_valid = 1'b0;
      @(negedge clk);
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL loop_abort: got busy=%b want 0", busy); else passCount++;
      tick();
   endtask

   task automatic test_write_port();
      instruction = INS_BEQ;
      instr_valid = 1'b1;
      ex_cond = 1'b0;
      ucode_we = 1'b1;
      ucode_waddr = 9'h180;
      ucode_wdata = {21'h7, 2'b00, 9'h000};
      @(negedge clk);
      checkCount++; if ({ctrl_signals, instr_done} !== {21'h4, 1'b1}) $display("[TB] FAIL wr_old_data: got ctrl=%h done=%b want 4/1", ctrl_signals, instr_done); else passCount++;
      tick();
      ucode_we = 1'b0;
      mCtrl['h180] = 21'h7;
      @(negedge clk);
      checkCount++; if ({ctrl_signals, instr_done} !== {21'h7, 1'b1}) $display("[TB] FAIL wr_new_data: got ctrl=%h done=%b want 7/1", ctrl_signals, instr_done); else passCount++;
      instr_valid = 1'b0;
      tick();
   endtask

   task automatic test_aw10();
      we10 = 1'b1;
      waddr10 = 10'h2C1;
      wdata10 = {21'h9, 2'b00, 10'h000};
      tick();
      waddr10 = 10'h0C1;
      wdata10 = {21'h6, 2'b00, 10'h000};
      tick();
      we10 = 1'b0;
      instruction = INS_SUB;
      instr_valid = 1'b1;
      @(negedge clk);
      checkCount++; if (upc10 !== 10'h0C1) $display("[TB] FAIL aw10_upc: got %h want 0c1", upc10); else passCount++;
      checkCount++; if ({ctrl10, done10} !== {21'h6, 1'b1}) $display("[TB] FAIL aw10_word: got ctrl=%h done=%b want 6/1", ctrl10, done10); else passCount++;
      instr_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [31:0] ins;
      int addrs [4];
      int ops [4];
      int ctrls [4];
      int nSteps, base, dly, wa;
      step_t e;
      for (int n = 0; n < 30; n++) begin
         ins = $urandom;
         ins[6:0] = opcTab[$urandom_range(0, 6)];
         nSteps = $urandom_range(1, 4);
         base = $urandom_range(0, 44);
         for (int j = 0; j < nSteps; j++) begin
            addrs[j] = (j == 0) ? dispAddr(ins) : ('h1C0 + base + j - 1);
            ctrls[j] = $urandom_range(1, 'h1FFFFF);
            if (j < nSteps - 1) ops[j] = $urandom_range(OP_NEXT, OP_BRANCH);
            else ops[j] = ($urandom_range(0, 1) == 1) ? OP_END : OP_BRANCH;
         end
         for (int j = 0; j < nSteps; j++)
            writeWord(addrs[j], ctrls[j], ops[j], (j < nSteps - 1) ? addrs[j + 1] : $urandom_range(0, 511));
         trace.delete();
         for (int j = 0; j < nSteps; j++) begin
            e.addr = addrs[j];
            e.ctrl = ctrls[j];
            e.done = 1'b0;
            e.busy = 1'b0;
            if (ops[j] == OP_WAIT) begin
               dly = $urandom_range(0, 4);
               repeat (dly) begin
                  e.mr = 1'b0;
                  e.cond = 1'($urandom_range(0, 1));
                  trace.push_back(e);
               end
               e.mr = 1'b1;
            end else begin
               e.mr = 1'($urandom_range(0, 1));
            end
            e.cond = (ops[j] == OP_BRANCH) ? (j < nSteps - 1) : 1'($urandom_range(0, 1));
            trace.push_back(e);
         end
         foreach (trace[i]) begin
            trace[i].busy = (i > 0);
            trace[i].done = (i == trace.size() - 1);
         end
         instruction = ins;
         foreach (trace[i]) begin
            instr_valid = 1'b1;
            mem_ready = trace[i].mr;
            ex_cond = trace[i].cond;
            if ($urandom_range(0, 3) == 0) begin
               wa = 'h1F8 + $urandom_range(0, 7);
               ucode_we = 1'b1;
               ucode_waddr = wa[8:0];
               ucode_wdata = $urandom;
               mCtrl[wa] = ucode_wdata[31:11];
            end
            @(negedge clk);
            checkCount++;
            if ({upc, ctrl_signals, instr_done, busy} !== {9'(trace[i].addr), 21'(trace[i].ctrl), trace[i].done, trace[i].busy})
               $display("[TB] FAIL rand%0d_step%0d: got upc=%h ctrl=%h done=%b busy=%b want upc=%h ctrl=%h done=%b busy=%b",
                        n, i, upc, ctrl_signals, instr_done, busy, 9'(trace[i].addr), 21'(trace[i].ctrl), trace[i].done, trace[i].busy);
            else passCount++;
            tick();
            ucode_we = 1'b0;
         end
         instr_valid = 1'b0;
         mem_ready = 1'b0;
         ex_cond = 1'b0;
         @(negedge clk);
         checkCount++;
         if ({busy, instr_done, ctrl_signals} !== 23'h0)
            $display("[TB] FAIL rand%0d_idle: got busy=%b done=%b ctrl=%h want all 0", n, busy, instr_done, ctrl_signals);
         else passCount++;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      instruction = '0;
      instr_valid = 1'b0;
      mem_ready = 1'b0;
      ex_cond = 1'b0;
      ex_abort = 1'b0;
      ucode_we = 1'b0;
      ucode_waddr = '0;
      ucode_wdata = '0;
      we10 = 1'b0;
      waddr10 = '0;
      wdata10 = '0;
      for (int i = 0; i < 512; i++) mCtrl[i] = '0;
      tick();
      test_reset();
      test_end_op();
      test_wait();
      test_timeout();
      test_branch();
      test_abort_reset();
      test_write_port();
      test_aw10();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
